// File: rtl/hp_hud_pkg.sv
// Shared types and constants for the HP heads-up display.
package hp_hud_pkg;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HURT  = 2'd1,
    DEAD  = 2'd2
  } hp_state_t;

  localparam int unsigned TILE_W = 12;
  localparam int unsigned TILE_H = 16;
  localparam int unsigned ROM_AW = 8;

endpackage

// File: rtl/hp_tile_locator.sv
// Per-pixel tile hit detection: finds which HP tile (if any) covers DrawX/DrawY
// and the pixel offset inside it, using one comparator pair per tile.
module hp_tile_locator
  import hp_hud_pkg::*;
#(
  parameter int unsigned MAX_HP   = 5,
  parameter int unsigned HUD_X0   = 40,
  parameter int unsigned HUD_Y0   = 24,
  parameter int unsigned TILE_GAP = 4
) (
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       hit,
  output logic [2:0] tile_idx,
  output logic [3:0] local_x,
  output logic [3:0] local_y
);

  localparam int unsigned PITCH = TILE_W + TILE_GAP;

  logic [31:0] x_pos;
  logic [31:0] y_pos;
  logic        y_in;

  assign x_pos = {22'd0, DrawX};
  assign y_pos = {22'd0, DrawY};
  assign y_in  = (y_pos >= HUD_Y0) && (y_pos < HUD_Y0 + TILE_H);

  always_comb begin
    hit      = 1'b0;
    tile_idx = '0;
    local_x  = '0;
    local_y  = '0;
    if (y_in) begin
      for (int unsigned k = 0; k < MAX_HP; k++) begin
        if (x_pos >= HUD_X0 + k * PITCH && x_pos < HUD_X0 + k * PITCH + TILE_W) begin
          hit      = 1'b1;
          tile_idx = 3'(k);
          local_x  = 4'(x_pos - HUD_X0 - k * PITCH);
        end
      end
    end
    if (hit) begin
      local_y = 4'(y_pos - HUD_Y0);
    end
  end

endmodule

// File: rtl/hp_hud_controller.sv
// HP state machine (ALIVE/HURT/DEAD) plus a one-cycle registered HUD renderer
// that draws MAX_HP full/empty mask tiles and blinks filled tiles while hurt.
module hp_hud_controller
  import hp_hud_pkg::*;
#(
  parameter int unsigned MAX_HP      = 5,
  parameter int unsigned HUD_X0      = 40,
  parameter int unsigned HUD_Y0      = 24,
  parameter int unsigned TILE_GAP    = 4,
  parameter int unsigned HURT_FRAMES = 30
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic       frame_tick,
  input  logic       damage,
  input  logic       heal,
  output logic [7:0] rom_address,
  output logic       hp_on,
  output logic       mask_full,
  output logic [2:0] hp_count,
  output logic       dead
);

  // At least 3 bits so the blink phase bit always exists.
  localparam int unsigned FC_W = ($clog2(HURT_FRAMES + 1) < 3) ? 3 : $clog2(HURT_FRAMES + 1);

  hp_state_t       state, state_n;
  logic [2:0]      hp_n;
  logic [FC_W-1:0] frame_cnt, frame_cnt_n;
  logic            dmg_req, heal_req;

  assign dmg_req  = damage && !heal;
  assign heal_req = heal && !damage;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state     <= ALIVE;
      hp_count  <= 3'(MAX_HP);
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      hp_count  <= hp_n;
      frame_cnt <= frame_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    hp_n        = hp_count;
    frame_cnt_n = frame_cnt;
    unique case (state)
      ALIVE: begin
        if (dmg_req) begin
          hp_n = hp_count - 3'd1;
          if (hp_count == 3'd1) begin
            state_n = DEAD;
          end else begin
            state_n     = HURT;
            frame_cnt_n = '0;
          end
        end else if (heal_req && hp_count < 3'(MAX_HP)) begin
          hp_n = hp_count + 3'd1;
        end
      end
      HURT: begin
        if (heal_req && hp_count < 3'(MAX_HP)) begin
          hp_n = hp_count + 3'd1;
        end
        if (frame_tick) begin
          if (frame_cnt == FC_W'(HURT_FRAMES - 1)) begin
            state_n     = ALIVE;
            frame_cnt_n = '0;
          end else begin
            frame_cnt_n = frame_cnt + 1'b1;
          end
        end
      end
      DEAD: begin
        state_n = DEAD;
      end
      default: begin
        state_n = ALIVE;
      end
    endcase
  end

  assign dead = (state == DEAD);

  logic       hit;
  logic [2:0] tile_idx;
  logic [3:0] local_x;
  logic [3:0] local_y;

  hp_tile_locator #(
    .MAX_HP  (MAX_HP),
    .HUD_X0  (HUD_X0),
    .HUD_Y0  (HUD_Y0),
    .TILE_GAP(TILE_GAP)
  ) u_locator (
    .DrawX   (DrawX),
    .DrawY   (DrawY),
    .hit     (hit),
    .tile_idx(tile_idx),
    .local_x (local_x),
    .local_y (local_y)
  );

  logic       visible;
  logic       filled;
  logic       blink_off;
  logic [7:0] addr;

  assign visible   = blank && hit;
  assign filled    = tile_idx < hp_count;
  assign blink_off = (state == HURT) && frame_cnt[2] && filled;
  assign addr      = 8'(local_y) * 8'(TILE_W) + 8'(local_x);

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_address <= '0;
      hp_on       <= 1'b0;
      mask_full   <= 1'b0;
    end else begin
      rom_address <= visible ? addr : '0;
      hp_on       <= visible && !blink_off;
      mask_full   <= visible && filled;
    end
  end

endmodule
